// File: rtl/delayed_autocorr.sv
// Sliding-window delayed autocorrelator P[n] = sum x[n-k]*conj(x[n-k-DELAY]); 2-cycle latency, no backpressure (always accepts).
// Define AUTOCORR_ENERGY_EN to add o_energy, the windowed lagged-sample energy R[n].

module complex_conjugate #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] i_real,
    input  logic signed [WIDTH-1:0] i_imag,
    output logic signed [WIDTH:0]   o_real,
    output logic signed [WIDTH:0]   o_imag
);
    // One extra bit so negating the most negative imaginary value stays exact
    assign o_real = (WIDTH+1)'(i_real);
    assign o_imag = -((WIDTH+1)'(i_imag));
endmodule

module delayed_autocorr #(
    parameter int WIDTH     = 16,
    parameter int DELAY     = 16,
    parameter int WINDOW    = 16,
    parameter int ACC_WIDTH = 2*WIDTH+1+$clog2(WINDOW)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic                        i_clear,
    input  logic signed [WIDTH-1:0]     i_real,
    input  logic signed [WIDTH-1:0]     i_imag,
    output logic                        o_valid,
    output logic signed [ACC_WIDTH-1:0] o_corr_real,
    output logic signed [ACC_WIDTH-1:0] o_corr_imag,
    output logic                        o_primed
`ifdef AUTOCORR_ENERGY_EN
    ,
    output logic signed [ACC_WIDTH-1:0] o_energy
`endif
);
    localparam int PW  = 2*WIDTH+1;
    localparam int TOT = DELAY+WINDOW;
    localparam int CW  = $clog2(TOT+1);

    logic signed [WIDTH-1:0]     r_dly_re [DELAY];
    logic signed [WIDTH-1:0]     r_dly_im [DELAY];
    logic signed [PW-1:0]        r_pf_re  [WINDOW];
    logic signed [PW-1:0]        r_pf_im  [WINDOW];
    logic signed [PW-1:0]        r_p_re;
    logic signed [PW-1:0]        r_p_im;
    logic                        r_p_vld;
    logic signed [ACC_WIDTH-1:0] r_acc_re;
    logic signed [ACC_WIDTH-1:0] r_acc_im;
    logic                        r_acc_vld;
    logic [CW-1:0]               r_cnt;
    logic                        r_primed;

    logic signed [WIDTH-1:0]     w_d_re;
    logic signed [WIDTH-1:0]     w_d_im;
    logic signed [WIDTH:0]       w_cj_re;
    logic signed [WIDTH:0]       w_cj_im;
    logic signed [PW-1:0]        w_xr;
    logic signed [PW-1:0]        w_xi;
    logic signed [PW-1:0]        w_cr;
    logic signed [PW-1:0]        w_ci;
    logic signed [PW-1:0]        w_p_re;
    logic signed [PW-1:0]        w_p_im;

    // Oldest delay-line entry is x[n-DELAY]; zero until the line has filled
    assign w_d_re = r_dly_re[DELAY-1];
    assign w_d_im = r_dly_im[DELAY-1];

    complex_conjugate #(.WIDTH(WIDTH)) u_conj (
        .i_real (w_d_re),
        .i_imag (w_d_im),
        .o_real (w_cj_re),
        .o_imag (w_cj_im)
    );

    assign w_xr   = PW'(i_real);
    assign w_xi   = PW'(i_imag);
    assign w_cr   = PW'(w_cj_re);
    assign w_ci   = PW'(w_cj_im);
    assign w_p_re = w_xr*w_cr - w_xi*w_ci;
    assign w_p_im = w_xr*w_ci + w_xi*w_cr;

`ifdef AUTOCORR_ENERGY_EN
    logic signed [PW-1:0]        r_ef [WINDOW];
    logic signed [PW-1:0]        r_e;
    logic signed [ACC_WIDTH-1:0] r_acc_e;
    logic signed [PW-1:0]        w_dr;
    logic signed [PW-1:0]        w_di;
    logic signed [PW-1:0]        w_e;

    assign w_dr = PW'(w_d_re);
    assign w_di = PW'(w_d_im);
    assign w_e  = w_dr*w_dr + w_di*w_di;
    assign o_energy = r_acc_e;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_dly_re[i] <= '0;
                r_dly_im[i] <= '0;
            end
            for (int i = 0; i < WINDOW; i++) begin
                r_pf_re[i] <= '0;
                r_pf_im[i] <= '0;
`ifdef AUTOCORR_ENERGY_EN
                r_ef[i]    <= '0;
`endif
            end
            r_p_re    <= '0;
            r_p_im    <= '0;
            r_p_vld   <= 1'b0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_acc_vld <= 1'b0;
            r_cnt     <= '0;
            r_primed  <= 1'b0;
`ifdef AUTOCORR_ENERGY_EN
            r_e       <= '0;
            r_acc_e   <= '0;
`endif
        end else if (i_clear) begin
            // Clear wins over a coincident sample, which is discarded
            for (int i = 0; i < DELAY; i++) begin
                r_dly_re[i] <= '0;
                r_dly_im[i] <= '0;
            end
            for (int i = 0; i < WINDOW; i++) begin
                r_pf_re[i] <= '0;
                r_pf_im[i] <= '0;
`ifdef AUTOCORR_ENERGY_EN
                r_ef[i]    <= '0;
`endif
            end
            r_p_re    <= '0;
            r_p_im    <= '0;
            r_p_vld   <= 1'b0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_acc_vld <= 1'b0;
            r_cnt     <= '0;
            r_primed  <= 1'b0;
`ifdef AUTOCORR_ENERGY_EN
            r_e       <= '0;
            r_acc_e   <= '0;
`endif
        end else begin
            r_p_vld   <= i_valid;
            r_acc_vld <= r_p_vld;
            // Lags the counter by one edge so it rises with the matching o_valid
            r_primed  <= (r_cnt == CW'(TOT));
            if (i_valid) begin
                r_dly_re[0] <= i_real;
                r_dly_im[0] <= i_imag;
                for (int i = 1; i < DELAY; i++) begin
                    r_dly_re[i] <= r_dly_re[i-1];
                    r_dly_im[i] <= r_dly_im[i-1];
                end
                r_p_re <= w_p_re;
                r_p_im <= w_p_im;
`ifdef AUTOCORR_ENERGY_EN
                r_e    <= w_e;
`endif
                if (r_cnt != CW'(TOT))
                    r_cnt <= r_cnt + CW'(1);
            end
            if (r_p_vld) begin
                r_pf_re[0] <= r_p_re;
                r_pf_im[0] <= r_p_im;
                for (int i = 1; i < WINDOW; i++) begin
                    r_pf_re[i] <= r_pf_re[i-1];
                    r_pf_im[i] <= r_pf_im[i-1];
                end
                r_acc_re <= r_acc_re + ACC_WIDTH'(r_p_re) - ACC_WIDTH'(r_pf_re[WINDOW-1]);
                r_acc_im <= r_acc_im + ACC_WIDTH'(r_p_im) - ACC_WIDTH'(r_pf_im[WINDOW-1]);
`ifdef AUTOCORR_ENERGY_EN
                r_ef[0] <= r_e;
                for (int i = 1; i < WINDOW; i++)
                    r_ef[i] <= r_ef[i-1];
                r_acc_e <= r_acc_e + ACC_WIDTH'(r_e) - ACC_WIDTH'(r_ef[WINDOW-1]);
`endif
            end
        end
    end

    assign o_valid     = r_acc_vld;
    assign o_corr_real = r_acc_re;
    assign o_corr_imag = r_acc_im;
    assign o_primed    = r_primed;

endmodule
